// File: rtl/data_cache_sa.sv
// N-way set-associative, write-back, write-allocate data cache with stall-based miss handling.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module data_cache_sa #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  write_en_i,
  input  logic [3:0]            byte_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  stall_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [31:0]           hit_count_o,
  output logic [31:0]           miss_count_o
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state_q, state_d;

  logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
  logic [TAG_W-1:0]      tag_q   [NUM_WAYS][NUM_SETS];
  logic [DATA_WIDTH-1:0] data_q  [NUM_WAYS][NUM_SETS];

  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic [NUM_WAYS-1:0] match;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim;
  logic [WAY_W-1:0]    victim_q;
  logic [WAY_W-1:0]    rr_ptr;
  logic                victim_vld_q;
  logic                hit;
  logic                idle_hit;
  logic                miss;
  logic                unused_addr_lsb;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] new_word,
                                                        input logic [3:0]            be);
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

  assign index           = addr_i[2+IDX_W-1:2];
  assign tag             = addr_i[ADDR_WIDTH-1:2+IDX_W];
  assign unused_addr_lsb = ^addr_i[1:0];

  always_comb begin
    match   = '0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = valid_q[index][w] && (tag_q[w][index] == tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
    end
  end

  assign hit         = req_i && (|match);
  assign idle_hit    = (state_q == IDLE) && hit;
  assign miss        = (state_q == IDLE) && req_i && !(|match);
  assign read_data_o = hit ? data_q[hit_way][index] : '0;

  // Victim: lowest invalid way wins, otherwise the set's round-robin pointer.
  always_comb begin
    logic found;
    victim = rr_ptr;
    found  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!found && !valid_q[index][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  generate
    if (NUM_WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_q [NUM_SETS];
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int s = 0; s < NUM_SETS; s++) rr_q[s] <= '0;
        end else if (state_q == REFILL && mem_ack_i && victim_vld_q) begin
          rr_q[index] <= (rr_q[index] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[index] + 1'b1;
        end
      end
      assign rr_ptr = rr_q[index];
    end else begin : g_dm
      assign rr_ptr = '0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Victim is frozen at miss detection so the pointer update cannot move it mid-transaction.
  always_ff @(posedge clk_i) begin
    if (miss) begin
      victim_q     <= victim;
      victim_vld_q <= valid_q[index][victim];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state_q)
        IDLE:      if (idle_hit && write_en_i) dirty_q[index][hit_way] <= 1'b1;
        WRITEBACK: if (mem_ack_i) dirty_q[index][victim_q] <= 1'b0;
        REFILL: begin
          if (mem_ack_i) begin
            valid_q[index][victim_q] <= 1'b1;
            dirty_q[index][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (idle_hit && write_en_i) begin
      data_q[hit_way][index] <= merge_bytes(data_q[hit_way][index], write_data_i, byte_en_i);
    end else if (state_q == REFILL && mem_ack_i) begin
      data_q[victim_q][index] <= mem_rdata_i;
      tag_q[victim_q][index]  <= tag;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          stall_o = 1'b1;
          state_d = (valid_q[index][victim] && dirty_q[index][victim]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[victim_q][index], index, 2'b00};
        mem_wdata_o = data_q[victim_q][index];
        if (mem_ack_i) state_d = REFILL;
      end
      REFILL: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {addr_i[ADDR_WIDTH-1:2], 2'b00};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit) hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss)     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_data_cache_sa.sv
// Directed bench for data_cache_sa (2-way, 64 sets): hits, stores, clean/dirty misses, round-robin, reset mid-refill.
module tb_data_cache_sa;
  logic        clk = 1'b0;
  logic        rst_i, req_i, write_en_i;
  logic [3:0]  byte_en_i;
  logic [31:0] addr_i, write_data_i, read_data_o;
  logic        stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [31:0] hit_count_o, miss_count_o;

`ifdef CACHE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  int checks = 0;
  int errors = 0;

  data_cache_sa #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SETS(64), .NUM_WAYS(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .write_en_i(write_en_i),
    .byte_en_i(byte_en_i), .addr_i(addr_i), .write_data_i(write_data_i),
    .read_data_o(read_data_o), .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int n);
    return (STATS != 0) ? 32'(n) : 32'd0;
  endfunction

  // Holds one CPU access until stall drops, acking each memory request on its lat-th cycle.
  task automatic access(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] fill, input int lat,
                        output int stalls, output int wbs, output logic [31:0] wb_addr,
                        output logic [31:0] wb_data, output int rfs, output logic [31:0] rf_addr,
                        output logic [31:0] rdata, output logic mreq_hit);
    int  reqcyc;
    logic done;
    stalls = 0; wbs = 0; rfs = 0; reqcyc = 0; done = 1'b0; mreq_hit = 1'b0;
    wb_addr = '0; wb_data = '0; rf_addr = '0; rdata = '0;
    req_i = 1'b1; write_en_i = we; byte_en_i = be; addr_i = a; write_data_i = wd;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (!stall_o) begin
        rdata    = read_data_o;
        mreq_hit = mem_req_o;
        done     = 1'b1;
      end else begin
        stalls++;
        if (mem_req_o) begin
          reqcyc++;
          if (reqcyc == lat) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = fill;
            reqcyc      = 0;
            if (mem_we_o) begin
              wbs++; wb_addr = mem_addr_o; wb_data = mem_wdata_o;
            end else begin
              rfs++; rf_addr = mem_addr_o;
            end
          end
        end
        @(negedge clk);
        mem_ack_i = 1'b0;
      end
    end
    check("access_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    req_i = 1'b0; write_en_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, wb, rf;
    logic [31:0] wa, wdat, ra, rd;
    logic mh;
    rst_i = 1'b1; req_i = 1'b0; write_en_i = 1'b0; byte_en_i = '0;
    addr_i = '0; write_data_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_hits", hit_count_o, 32'd0);
    check("rst_misses", miss_count_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    // Cold miss, ack on the third request cycle.
    access(32'h100, 1'b0, 4'h0, 32'h0, 32'hDEADBEEF, 3, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t1_stalls", 32'(st), 32'd4);
    check("t1_refills", 32'(rf), 32'd1);
    check("t1_refill_addr", ra, 32'h100);
    check("t1_wbs", 32'(wb), 32'd0);
    check("t1_data", rd, 32'hDEADBEEF);
    check("t1_misses", miss_count_o, cnt(1));
    check("t1_hits", hit_count_o, cnt(1));

    access(32'h100, 1'b0, 4'h0, 32'h0, 32'h0, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t2_stalls", 32'(st), 32'd0);
    check("t2_mem_req", {31'd0, mh}, 32'd0);
    check("t2_data", rd, 32'hDEADBEEF);
    check("t2_hits", hit_count_o, cnt(2));

    access(32'h100, 1'b1, 4'b0001, 32'h000000AA, 32'h0, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t3_store_stalls", 32'(st), 32'd0);
    check("t3_store_mem_req", {31'd0, mh}, 32'd0);
    access(32'h100, 1'b0, 4'h0, 32'h0, 32'h0, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t4_merged", rd, 32'hDEADBEAA);
    check("t4_stalls", 32'(st), 32'd0);

    // Second way of set 0, clean fill, minimum penalty.
    access(32'h200, 1'b0, 4'h0, 32'h0, 32'h22222222, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t5_stalls", 32'(st), 32'd2);
    check("t5_refill_addr", ra, 32'h200);
    check("t5_data", rd, 32'h22222222);

    // Set full: round-robin picks way 0, which is dirty.
    access(32'h300, 1'b0, 4'h0, 32'h0, 32'h33333333, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t6_stalls", 32'(st), 32'd3);
    check("t6_wbs", 32'(wb), 32'd1);
    check("t6_wb_addr", wa, 32'h100);
    check("t6_wb_data", wdat, 32'hDEADBEAA);
    check("t6_refill_addr", ra, 32'h300);
    check("t6_data", rd, 32'h33333333);
    check("t6_misses", miss_count_o, cnt(3));
    check("t6_hits", hit_count_o, cnt(6));

    access(32'h200, 1'b0, 4'h0, 32'h0, 32'h0, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t7_stalls", 32'(st), 32'd0);
    check("t7_data", rd, 32'h22222222);

    // Pointer now at way 1 (clean 0x200): evicted without writeback.
    access(32'h100, 1'b0, 4'h0, 32'h0, 32'hDEADBEAA, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t8_stalls", 32'(st), 32'd2);
    check("t8_wbs", 32'(wb), 32'd0);
    check("t8_data", rd, 32'hDEADBEAA);
    access(32'h300, 1'b0, 4'h0, 32'h0, 32'h0, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t9_stalls", 32'(st), 32'd0);
    check("t9_data", rd, 32'h33333333);

    // Store miss: allocate then merge byte 2.
    access(32'h404, 1'b1, 4'b0100, 32'h00550000, 32'h11111111, 2, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t10_stalls", 32'(st), 32'd3);
    check("t10_refill_addr", ra, 32'h404);
    access(32'h404, 1'b0, 4'h0, 32'h0, 32'h0, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("t11_data", rd, 32'h11551111);
    check("t11_misses", miss_count_o, cnt(5));
    check("t11_hits", hit_count_o, cnt(11));

    // Idle: no request reads zero, stray ack ignored.
    addr_i = 32'h100; mem_ack_i = 1'b1;
    #1;
    check("idle_rdata", read_data_o, 32'h0);
    @(negedge clk);
    mem_ack_i = 1'b0;
    #1;
    check("idle_ack_req", {31'd0, mem_req_o}, 32'd0);
    check("idle_ack_stall", {31'd0, stall_o}, 32'd0);
    check("idle_hits", hit_count_o, cnt(11));

    // Reset while a refill is outstanding.
    @(negedge clk);
    req_i = 1'b1; addr_i = 32'h500; write_en_i = 1'b0;
    #1;
    check("r_miss_stall", {31'd0, stall_o}, 32'd1);
    @(negedge clk);
    #1;
    check("r_refill_req", {31'd0, mem_req_o}, 32'd1);
    check("r_refill_we", {31'd0, mem_we_o}, 32'd0);
    check("r_refill_addr", mem_addr_o, 32'h500);
    rst_i = 1'b1; req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("r_mem_req", {31'd0, mem_req_o}, 32'd0);
    check("r_stall", {31'd0, stall_o}, 32'd0);
    check("r_misses", miss_count_o, 32'd0);
    check("r_hits", hit_count_o, 32'd0);

    access(32'h100, 1'b0, 4'h0, 32'h0, 32'hDEADBEAA, 1, st, wb, wa, wdat, rf, ra, rd, mh);
    check("r_reload_stalls", 32'(st), 32'd2);
    check("r_reload_refills", 32'(rf), 32'd1);
    check("r_reload_data", rd, 32'hDEADBEAA);
    check("r_reload_misses", miss_count_o, cnt(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
